branch_history_checkpoint: RTL and testbench

Checkpoint queue for the global branch history register: records the pre-shift history and predicted direction of every in-flight branch, and on in-order resolution detects mispredictions. On a mispredict it produces the corrected history value to reload into the history register. Sits between the predictor front end, which shifts predicted outcomes into the history, and the branch resolution stage, which supplies actual outcomes.

---
 rtl/branch_pred_pkg.sv | 20 ++
 rtl/checkpoint_fifo.sv | 61 ++++++
 rtl/branch_history_checkpoint.sv | 87 ++++++++
 tb/tb_branch_history_checkpoint.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared branch-prediction types and the history restore computation used by
// both the checkpoint queue and the global history register.
package branch_pred_pkg;

  localparam int unsigned GHR_BITS = 2;

  typedef struct packed {
    logic [GHR_BITS-1:0] history;
    logic                predTaken;
  } checkpoint_t;

  // New outcome enters at the MSB and the history shifts toward the LSB.
  function automatic logic [GHR_BITS-1:0] restore_history(
    input logic [GHR_BITS-1:0] history,
    input logic                taken
  );
    return GHR_BITS'({taken, history} >> 1);
  endfunction

endpackage

// File: rtl/checkpoint_fifo.sv
// Circular checkpoint storage with separate occupancy count and a synchronous
// flush that empties the queue by snapping head to tail.
module checkpoint_fifo #(
  parameter  int unsigned W     = 3,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/branch_history_checkpoint.sv
// Branch history checkpoint queue: compares in-order resolutions against the
// stored predictions and emits the corrected history on a mispredict.
module branch_history_checkpoint
  import branch_pred_pkg::*;
#(
  parameter  int unsigned HIST_BITS = 2,
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 predictValid,
  input  logic                 predictTaken,
  input  logic [HIST_BITS-1:0] historyIn,
  output logic                 predictReady,
  input  logic                 resolveValid,
  input  logic                 resolveTaken,
  output logic                 restoreValid,
  output logic [HIST_BITS-1:0] restoreHistory,
  output logic [CW-1:0]        count,
  output logic                 resolveError
);

  logic [HIST_BITS:0]   head_entry;
  logic [HIST_BITS-1:0] corrected;
  logic                 push, pop, mispredict, empty;

  logic                 restore_valid_q, restore_valid_d;
  logic [HIST_BITS-1:0] restore_history_q, restore_history_d;
  logic                 resolve_error_q, resolve_error_d;

  assign predictReady = (count != CW'(DEPTH));
  assign empty        = (count == '0);
  assign pop          = resolveValid && !empty;
  assign mispredict   = pop && (resolveTaken != head_entry[0]);
  // A push alongside a mispredict is on the wrong path and is dropped.
  assign push         = predictValid && predictReady && !mispredict;

  checkpoint_fifo #(
    .W     (HIST_BITS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({historyIn, predictTaken}),
    .pop       (pop),
    .flush     (mispredict),
    .head_data (head_entry),
    .count     (count)
  );

  generate
    if (HIST_BITS == GHR_BITS) begin : g_shared_restore
      checkpoint_t head_cp;
      assign head_cp   = head_entry;
      assign corrected = restore_history(head_cp.history, resolveTaken);
    end else begin : g_local_restore
      assign corrected = HIST_BITS'({resolveTaken, head_entry[HIST_BITS:1]} >> 1);
    end
  endgenerate

  always_comb begin
    restore_valid_d   = mispredict;
    restore_history_d = restore_history_q;
    resolve_error_d   = resolve_error_q;
    if (mispredict) restore_history_d = corrected;
    if (resolveValid && empty) resolve_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      restore_valid_q   <= 1'b0;
      restore_history_q <= '0;
      resolve_error_q   <= 1'b0;
    end else begin
      restore_valid_q   <= restore_valid_d;
      restore_history_q <= restore_history_d;
      resolve_error_q   <= resolve_error_d;
    end
  end

  assign restoreValid   = restore_valid_q;
  assign restoreHistory = restore_history_q;
  assign resolveError   = resolve_error_q;

endmodule

// File: tb/tb_branch_history_checkpoint.sv
// Directed bench for branch_history_checkpoint with hand-computed expectations.
module tb_branch_history_checkpoint;

  logic       clk = 1'b0;
  logic       reset;
  logic       predictValid, predictTaken;
  logic [1:0] historyIn;
  logic       predictReady;
  logic       resolveValid, resolveTaken;
  logic       restoreValid;
  logic [1:0] restoreHistory;
  logic [2:0] count;
  logic       resolveError;

  int unsigned errors = 0;
  int unsigned checks = 0;

  branch_history_checkpoint #(
    .HIST_BITS (2),
    .DEPTH     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .predictValid   (predictValid),
    .predictTaken   (predictTaken),
    .historyIn      (historyIn),
    .predictReady   (predictReady),
    .resolveValid   (resolveValid),
    .resolveTaken   (resolveTaken),
    .restoreValid   (restoreValid),
    .restoreHistory (restoreHistory),
    .count          (count),
    .resolveError   (resolveError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [1:0] h, input logic pt,
                       input logic rv, input logic rt);
    predictValid = pv;
    historyIn    = h;
    predictTaken = pt;
    resolveValid = rv;
    resolveTaken = rt;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(predictReady), 32'd1);
    check({tag, "_rv"},    32'(restoreValid), 32'd0);
    check({tag, "_rh"},    32'(restoreHistory), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_err"},   32'(resolveError), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    check_reset_state("rst");
    tick();
    reset = 1'b1;
    tick();

    // Correct prediction: no restore
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0); tick();
    check("t1_count_push", 32'(count), 32'd1);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    check("t1_count_pop", 32'(count), 32'd0);
    check("t1_rv", 32'(restoreValid), 32'd0);

    // Mispredict restores {1, hist[1]}
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0); tick();
    check("t2_count", 32'(count), 32'd2);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    check("t2_rv", 32'(restoreValid), 32'd1);
    check("t2_rh", 32'(restoreHistory), 32'b11);
    check("t2_count", 32'(count), 32'd0);
    check("t2_ready", 32'(predictReady), 32'd1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("t2_rv_pulse", 32'(restoreValid), 32'd0);
    check("t2_rh_hold", 32'(restoreHistory), 32'b11);

    // Fill to DEPTH with pointer wrap, then drain in order
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(predictReady), 32'd0);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0); tick();
    check("t3_fifth_ignored", 32'(count), 32'd4);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    check("t3_pop0_rv", 32'(restoreValid), 32'd0);
    check("t3_pop0_count", 32'(count), 32'd3);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("t3_pop1_rv", 32'(restoreValid), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    check("t3_pop2_rv", 32'(restoreValid), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("t3_pop3_rv", 32'(restoreValid), 32'd0);
    check("t3_drained", 32'(count), 32'd0);
    check("t3_rh_hold", 32'(restoreHistory), 32'b11);

    // Push and correct pop together leave count unchanged
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b1); tick();
    check("t4_pushpop_count", 32'(count), 32'd1);
    check("t4_pushpop_rv", 32'(restoreValid), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("t4_second_rv", 32'(restoreValid), 32'd0);
    check("t4_second_count", 32'(count), 32'd0);

    // Mispredict with simultaneous push: push discarded
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
    check("t5_count", 32'(count), 32'd2);
    drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b1); tick();
    check("t5_rv", 32'(restoreValid), 32'd1);
    check("t5_rh", 32'(restoreHistory), 32'b10);
    check("t5_count", 32'(count), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("t5_push_absent", 32'(count), 32'd0);
    check("t5_no_err", 32'(resolveError), 32'd0);

    // Resolve with empty queue sets sticky error
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("t6_first_err", 32'(resolveError), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1); tick();
    check("t6_err", 32'(resolveError), 32'd1);
    check("t6_rv", 32'(restoreValid), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick(); tick();
    check("t6_err_sticky", 32'(resolveError), 32'd1);

    // Asynchronous reset while a mispredict is about to resolve
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
    check("t7_count3", 32'(count), 32'd3);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("t7_async");
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    check("t7_no_pulse", 32'(restoreValid), 32'd0);
    check("t7_count_after", 32'(count), 32'd0);
    tick();
    check("t7_no_pulse2", 32'(restoreValid), 32'd0);
    check("t7_rh_after", 32'(restoreHistory), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
